// File: rtl/dcache_core_responder.sv
// Scratchpad responder: one request outstanding, fixed access latency, 64-bit words.
// Define DCACHE_RESP_BOUNDS_CHECK_EN to reject addresses above the array and raise a sticky err.
module dcache_core_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [63:0] reqdata,
  input  logic [9:0]  reqtag,
  output logic        reqack,
  output logic        writeack,
  output logic        respcyc,
  output logic [63:0] resp,
  output logic [9:0]  resptag,
  input  logic        respack,
  output logic        err
);
  // state | meaning
  // IDLE  | waiting for reqcyc; blocked during the writeack cycle
  // BUSY  | latency countdown on the latched request
  // RESP  | read data presented, waiting for respack

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_nxt;

  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [63:0]           data_q;
  logic [9:0]            tag_q;
  logic                  oob_req, oob_q;
  logic                  accept, done, wr_done, rd_done, mem_wr;
  logic [63:0]           mem [WORDS];

`ifdef DCACHE_RESP_BOUNDS_CHECK_EN
  logic err_q;
  logic unused_low;
  assign oob_req    = |req[63:DEPTH_LOG2+3];
  assign unused_low = ^req[2:0];
  assign err        = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           err_q <= 1'b0;
    else if (done && oob_q) err_q <= 1'b1;
  end
`else
  // Upper address bits alias onto the array.
  logic unused_addr;
  assign oob_req     = 1'b0;
  assign unused_addr = ^{req[63:DEPTH_LOG2+3], req[2:0]};
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = tag_q[9] ? IDLE : RESP;
      RESP:    if (respack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    done    = 1'b0;
    wr_done = 1'b0;
    rd_done = 1'b0;
    mem_wr  = 1'b0;
    case (state)
      // The writeack cycle is already IDLE but must not accept, giving LATENCY+2 spacing.
      IDLE: accept = reqcyc && !writeack;
      BUSY: begin
        done    = (cnt == 4'd0);
        wr_done = done && tag_q[9];
        rd_done = done && !tag_q[9];
        mem_wr  = wr_done && tag_q[8] && !oob_q;
      end
      default: ;
    endcase
  end

  assign respcyc = (state == RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reqack   <= 1'b0;
      writeack <= 1'b0;
      cnt      <= 4'd0;
      idx_q    <= '0;
      data_q   <= '0;
      tag_q    <= '0;
      oob_q    <= 1'b0;
      resp     <= '0;
      resptag  <= '0;
    end else begin
      reqack   <= accept;
      writeack <= wr_done;
      if (accept) begin
        cnt    <= LOAD;
        idx_q  <= req[DEPTH_LOG2+2:3];
        data_q <= reqdata;
        tag_q  <= reqtag;
        oob_q  <= oob_req;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_done) begin
        resptag <= tag_q;
        if (!tag_q[8])  resp <= '0;
        else if (oob_q) resp <= '1;
        else            resp <= mem[idx_q];
      end
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[idx_q] <= data_q;
  end

endmodule

// File: tb/tb_dcache_core_responder.sv
// Bench for dcache_core_responder: directed requests, expectations queued and checked by a monitor.
module tb_dcache_core_responder;
  localparam int LAT = 4;

`ifdef DCACHE_RESP_BOUNDS_CHECK_EN
  localparam logic [63:0] OOB_EXP = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic        ERR_EXP = 1'b1;
`else
  localparam logic [63:0] OOB_EXP = 64'h0123_4567_89AB_CDEF;
  localparam logic        ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        reqcyc, reqack, writeack, respcyc, respack, err;
  logic [63:0] req, reqdata, resp;
  logic [9:0]  reqtag, resptag;

  logic        reqcyc1, reqack1, writeack1, respcyc1, respack1, err1;
  logic [63:0] req1, reqdata1, resp1;
  logic [9:0]  reqtag1, resptag1;

  dcache_core_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .reqcyc(reqcyc), .req(req), .reqdata(reqdata),
    .reqtag(reqtag), .reqack(reqack), .writeack(writeack), .respcyc(respcyc),
    .resp(resp), .resptag(resptag), .respack(respack), .err(err));

  dcache_core_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .reqcyc(reqcyc1), .req(req1), .reqdata(reqdata1),
    .reqtag(reqtag1), .reqack(reqack1), .writeack(writeack1), .respcyc(respcyc1),
    .resp(resp1), .resptag(resptag1), .respack(respack1), .err(err1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_wr;
    logic [63:0] data;
    logic [9:0]  tag;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          done_cnt     = 0;
  int          reqack_cnt   = 0;
  int          writeack_cnt = 0;
  int          ack_delay    = 0;
  int          wait_n       = 0;
  bit          last_write   = 1'b0;
  bit          resp_active  = 1'b0;
  logic [63:0] hold_resp;
  logic [9:0]  hold_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_reqack", reqack, 0);
    check("rst_writeack", writeack, 0);
    check("rst_respcyc", respcyc, 0);
    check("rst_resp", resp, 0);
    check("rst_resptag", resptag, 0);
    check("rst_err", err, 0);
  endtask

  // Monitor: pops the scoreboard on writeack or respcyc rise, drives respack.
  initial begin
    respack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb.delete();
        resp_active = 1'b0;
        respack     = 1'b0;
        last_write  = 1'b0;
      end else begin
        if (reqack) reqack_cnt++;
        if (writeack) begin
          writeack_cnt++;
          if (sb.size() == 0) check("unexpected_writeack", 1, 0);
          else begin
            mon_e = sb.pop_front();
            check("writeack_kind", mon_e.is_wr, 1);
            check("writeack_cycle", cyc, mon_e.due);
          end
          done_cnt++;
          last_write = 1'b1;
        end
        if (respcyc) begin
          if (!resp_active) begin
            resp_active = 1'b1;
            wait_n      = 0;
            hold_resp   = resp;
            hold_tag    = resptag;
            if (sb.size() == 0) check("unexpected_respcyc", 1, 0);
            else begin
              mon_e = sb.pop_front();
              check("resp_kind", mon_e.is_wr, 0);
              check("resp_data", resp, mon_e.data);
              check("resp_tag", resptag, mon_e.tag);
              check("resp_cycle", cyc, mon_e.due);
            end
          end else begin
            check("respcyc_after_respack", respack, 0);
            check("resp_stable", resp, hold_resp);
            check("resptag_stable", resptag, hold_tag);
          end
          respack = (wait_n == ack_delay);
          wait_n++;
        end else if (resp_active) begin
          check("resp_drop_after_ack", respack, 1);
          resp_active = 1'b0;
          respack     = 1'b0;
          last_write  = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  // Issue one request; the acceptance lag depends on whether the previous access was a write.
  task automatic do_req(input logic [63:0] a, input logic [63:0] d, input logic [9:0] t,
                        input logic [63:0] rexp, input int hold_extra, input bit wait_done);
    int   c0, got, start, lag;
    exp_t e;
    lag   = last_write ? 2 : 1;
    start = done_cnt;
    req = a; reqdata = d; reqtag = t; reqcyc = 1'b1;
    c0  = cyc;
    got = -1;
    for (int i = 0; i < 20 && got < 0; i++) begin
      @(negedge clk); #2;
      if (reqack) got = cyc;
    end
    check("reqack_cycle", got, c0 + lag);
    e.is_wr = t[9];
    e.data  = rexp;
    e.tag   = t;
    e.due   = got + LAT;
    sb.push_back(e);
    repeat (hold_extra) begin @(negedge clk); #2; end
    reqcyc = 1'b0;
    if (wait_done) begin
      for (int i = 0; i < 60 && done_cnt == start; i++) begin @(negedge clk); #2; end
      check("completion_seen", done_cnt != start, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  int ra, wa;

  initial begin
    reset_n = 1'b0;
    reqcyc = 1'b0; req = '0; reqdata = '0; reqtag = '0;
    reqcyc1 = 1'b0; req1 = '0; reqdata1 = '0; reqtag1 = '0; respack1 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    #2 reset_n = 1'b1;
    @(negedge clk); #2;

    // Basic write, then read with delayed respack
    ra = reqack_cnt; wa = writeack_cnt;
    do_req(64'h40, 64'hDEAD_BEEF, 10'h380, 64'h0, 0, 1);
    check("w1_reqack_pulses", reqack_cnt - ra, 1);
    check("w1_writeack_pulses", writeack_cnt - wa, 1);
    ack_delay = 3;
    do_req(64'h40, 64'h0, 10'h105, 64'hDEAD_BEEF, 0, 1);
    ack_delay = 0;

    // reqcyc held through the reqack cycle must not start a second access
    ra = reqack_cnt; wa = writeack_cnt;
    do_req(64'h48, 64'h1122_3344_5566_7788, 10'h3FF, 64'h0, 2, 1);
    check("hold_reqack_pulses", reqack_cnt - ra, 1);
    check("hold_writeack_pulses", writeack_cnt - wa, 1);
    do_req(64'h4D, 64'h0, 10'h17F, 64'h1122_3344_5566_7788, 0, 1);

    // Non-memory accesses
    do_req(64'h40, 64'h5555, 10'h200, 64'h0, 0, 1);
    do_req(64'h40, 64'h0, 10'h101, 64'hDEAD_BEEF, 0, 1);
    do_req(64'h48, 64'h0, 10'h07A, 64'h0, 0, 1);

    // Reset in the middle of a write abandons it
    do_req(64'h40, 64'hBAD0_BAD0, 10'h381, 64'h0, 0, 0);
    wa = writeack_cnt;
    @(negedge clk); #2;
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1 check_reset();
    @(negedge clk); #2;
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    #2 check("rst_no_writeack", writeack_cnt - wa, 0);
    do_req(64'h40, 64'h0, 10'h102, 64'hDEAD_BEEF, 0, 1);

    // Address above the array
    do_req(64'h0, 64'h0123_4567_89AB_CDEF, 10'h380, 64'h0, 0, 1);
    do_req(64'h2000, 64'h0, 10'h100, OOB_EXP, 0, 1);
    check("err_after_oob", err, ERR_EXP);
    do_req(64'h0, 64'h0, 10'h103, 64'h0123_4567_89AB_CDEF, 0, 1);
    check("err_sticky", err, ERR_EXP);

    // LATENCY=1 instance: write, next request raised in the writeack cycle, then read back
    req1 = 64'h8; reqdata1 = 64'hA5A5; reqtag1 = 10'h380; reqcyc1 = 1'b1;
    @(negedge clk); #2;
    check("l1_reqack", reqack1, 1);
    check("l1_no_early_writeack", writeack1, 0);
    reqcyc1 = 1'b0;
    @(negedge clk); #2;
    check("l1_writeack", writeack1, 1);
    check("l1_reqack_single", reqack1, 0);
    req1 = 64'h8; reqtag1 = 10'h100; reqcyc1 = 1'b1;
    @(negedge clk); #2;
    check("l1_blocked_in_writeack", reqack1, 0);
    check("l1_writeack_single", writeack1, 0);
    @(negedge clk); #2;
    check("l1_second_reqack", reqack1, 1);
    reqcyc1 = 1'b0;
    @(negedge clk); #2;
    check("l1_respcyc", respcyc1, 1);
    check("l1_resp", resp1, 64'hA5A5);
    check("l1_resptag", resptag1, 10'h100);
    respack1 = 1'b1;
    @(negedge clk); #2;
    check("l1_respcyc_drop", respcyc1, 0);
    respack1 = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_core_responder.md
DCACHE_CORE_RESPONDER -- requirements
Module: dcache_core_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set scratchpad size to 2^DEPTH_LOG2 64-bit words.
REQ-002 Parameter LATENCY, default 4, legal range 1..15, SHALL set access latency in cycles.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 reqcyc  in  1  request valid from initiator, held until reqack.
REQ-006 req  in  64  byte address; word index = req[DEPTH_LOG2+2:3].
REQ-007 reqdata  in  64  write data.
REQ-008 reqtag  in  10  [9]=WRITE(1)/READ(0), [8]=MEMORY, [7]=DATA, [6:0]=id.
REQ-009 reqack  out  1  one-cycle request-accepted pulse.
REQ-010 writeack  out  1  one-cycle write-complete pulse.
REQ-011 respcyc  out  1  read response valid, held until respack.
REQ-012 resp  out  64  read data.
REQ-013 resptag  out  10  tag of the request being answered.
REQ-014 respack  in  1  initiator consumed read response.
REQ-015 err  out  1  sticky out-of-range flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, BUSY, RESP; one request outstanding at a time.
REQ-017 IDLE with reqcyc=1 at edge T SHALL latch req, reqdata, reqtag, load counter with LATENCY-1, go BUSY, drive reqack=1 for cycle T+1 only.
REQ-018 reqcyc SHALL be ignored in BUSY and RESP; a reqcyc still high during the reqack cycle SHALL NOT start a second request.
REQ-019 BUSY SHALL decrement counter each cycle; on counter==0 the access completes.
REQ-020 Write completion (tag[9]=1, tag[8]=1): array word updated with latched reqdata, writeack=1 for cycle T+LATENCY+1, return to IDLE in that same cycle.
REQ-021 Read completion (tag[9]=0): go RESP, respcyc=1 from cycle T+LATENCY+1, resp=array word, resptag=latched tag; hold stable until respack sampled high.
REQ-022 RESP with respack=1 at an edge SHALL drop respcyc next cycle and return to IDLE.
REQ-023 tag[8]=0 (non-memory): acknowledged with identical timing, no array write, read resp=0.
REQ-024 Earliest next acceptance: reqcyc sampled in the first IDLE cycle after writeack or respcyc drop; back-to-back writes spaced LATENCY+2 cycles.
REQ-025 Read of a word written by an earlier completed write SHALL return that data; req[2:0] ignored.
REQ-026 counter width 4 bits; LATENCY=1 SHALL complete on the first BUSY cycle.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, counter 0, reqack=0, writeack=0, respcyc=0, resp=0, resptag=0, err=0.
REQ-028 Reset mid-BUSY or mid-RESP SHALL abandon the access with no writeack/respcyc and no array update.
REQ-029 Array contents are not reset.

Configuration
REQ-030 Macro DCACHE_RESP_BOUNDS_CHECK_EN defined: any set bit in req[63:DEPTH_LOG2+3] marks the request out-of-range; write dropped (writeack still pulses), read returns 64'hFFFF_FFFF_FFFF_FFFF, err set and held until reset.
REQ-031 Macro undefined: upper address bits ignored (aliasing), err tied 0.

Verification
REQ-032 Write req=0x40, data=0xDEADBEEF, tag=0x380, LATENCY=4 -> reqack at T+1, writeack at T+5, single pulses.
REQ-033 Read req=0x40 tag=0x105 after write -> respcyc at T+5, resp=0xDEADBEEF, resptag=0x105; respack delayed 3 cycles -> resp stable, respcyc drops after respack.
REQ-034 reqcyc held high 3 cycles through reqack -> exactly one reqack, one writeack.
REQ-035 reset_n pulsed low at T+3 of a write -> no writeack; subsequent read of that address returns prior value.
REQ-036 With DCACHE_RESP_BOUNDS_CHECK_EN, DEPTH_LOG2=10, read req=0x2000 -> resp=all ones, err=1 persistent; without macro -> resp=word 0, err=0.
REQ-037 LATENCY=1 write -> reqack T+1, writeack T+2; next request accepted at T+3.
